uart_transmitter: RTL and testbench
===================================

# uart_transmitter

Serial UART transmitter with a small input byte FIFO. It is the transmit-side counterpart to `UART_Receiver` and uses the same `CYCLES_PER_BIT` baud convention (217 = 115200 baud and 2604 = 9600 baud at 25 MHz). It serializes 8N1 frames, LSB first, onto a single TX line. Upstream logic pushes bytes with a valid/ready handshake, so back-to-back bytes go out with no idle gap.

## Interface
- `CYCLES_PER_BIT`, default 217: clock cycles per serial bit; minimum 2.
- `FIFO_DEPTH`, default 4: byte FIFO entries; a power of two, minimum 2.
- `i_clk`  in  1: system clock.
- `i_reset`  in  1: reset, synchronous, active-high.
- `i_tx_byte`  in  8: byte to transmit.
- `i_tx_valid`  in  1: upstream offers `i_tx_byte` this cycle.
- `o_tx_ready`  out  1: FIFO can accept; a push occurs when `i_tx_valid && o_tx_ready`.
- `o_serial_tx`  out  1: serial line, registered, idle high.
- `o_tx_active`  out  1: high while a frame is on the line (START through STOP).
- `o_tx_done`  out  1: one-cycle strobe in the last cycle of each stop bit.
- `o_fifo_count`  out  `$clog2(FIFO_DEPTH+1)`: bytes queued, excluding the byte being sent.

## Operation
- FIFO: circular buffer with read pointer, write pointer and count.
  - `o_tx_ready = (o_fifo_count < FIFO_DEPTH)`, driven combinationally from the registered count.
  - When full, a push is refused even if a pop happens in the same cycle.
  - A push and a pop in the same cycle leave the count unchanged.
  - Pointers wrap modulo `FIFO_DEPTH`.
- FSM states: IDLE, START, DATA, STOP. A bit counter runs 0..`CYCLES_PER_BIT`-1 and a data index runs 0..7.
- IDLE
  - Line is high.
  - If count > 0: pop the head byte into the shift register, clear the bit counter, go to START.
- START: line low for `CYCLES_PER_BIT` cycles, then go to DATA with index 0.
- DATA
  - Line = `shift[index]`, held `CYCLES_PER_BIT` cycles per bit.
  - After index 7 completes, go to STOP.
- STOP
  - Line high for `CYCLES_PER_BIT` cycles; `o_tx_done` = 1 in the final cycle.
  - At that final cycle's edge: if count > 0, pop and go directly to START (zero-gap streaming); otherwise go to IDLE.
- The byte being transmitted is held in the shift register. New pushes during a frame never disturb it.
- Reset mid-frame: the frame is abandoned, the line returns high on the reset edge, and queued bytes are discarded.
- Reset values: `o_serial_tx` = 1, `o_tx_active` = 0, `o_tx_done` = 0, `o_fifo_count` = 0, `o_tx_ready` = 1, state IDLE, pointers 0.

## Timing
- Push accepted at edge N: count = 1 after N.
  - If IDLE: pop at edge N+1; `o_serial_tx` = 0 and `o_tx_active` = 1 from N+1.
  - Latency from the accepting edge to the start bit on the line is 1 cycle.
- Frame length is exactly 10×`CYCLES_PER_BIT` cycles.
  - Start bit: cycles [0, C).
  - Data bit k: cycles [(1+k)·C, (2+k)·C).
  - Stop bit: cycles [9C, 10C).
- `o_tx_done` is high only in cycle 10C−1 of each frame.
- Back-to-back frames: the next start bit begins in the cycle immediately after the stop bit's last cycle, with no idle cycle.
- `o_tx_active` stays high across back-to-back frames and drops one cycle after the last frame's `o_tx_done`.
- A push arriving in a frame's last cycle while the FIFO is empty is not visible to that frame's pop decision. The FSM goes to IDLE, and the new frame starts 1 cycle later.

## Test plan
All directed scenarios use `CYCLES_PER_BIT` = 4 and `FIFO_DEPTH` = 4.
1. **Reset values.** Assert `i_reset` for 2 cycles → `o_serial_tx`=1, `o_tx_ready`=1, `o_fifo_count`=0, `o_tx_done`=0, `o_tx_active`=0.
2. **Single byte.** Push 0xA5 → line sequence in 4-cycle bits: 0, 1,0,1,0,0,1,0,1, 1.
   - Start bit falls 1 cycle after the accepting edge.
   - `o_tx_done` is high for exactly 1 cycle at cycle 39 of the frame.
   - Then IDLE with the line high.
3. **Back-to-back.** Push 0x00, 0xFF, 0x55 on consecutive cycles → three contiguous 40-cycle frames with no idle cycle between stop and start.
   - Three `o_tx_done` strobes, 40 cycles apart.
   - `o_tx_active` is continuously high for 120 cycles.
4. **Full FIFO.** Hold `i_tx_valid` high with incrementing bytes 0x01.. from idle.
   - 0x01 pops immediately; 0x02–0x05 fill the FIFO.
   - `o_tx_ready` goes low with count = 4, and bytes offered while it is low are not queued.
   - At each stop-bit end `o_tx_ready` rises and exactly one new byte is accepted.
   - Transmitted order is strictly ascending, with no drops or duplicates.
5. **Reset mid-frame.** Push 0x3C and 0xC3, then assert `i_reset` during data bit 3 → on the reset edge:
   - `o_serial_tx`=1, count=0, `o_tx_active`=0;
   - no `o_tx_done` is produced;
   - no frame follows.
6. **Last-cycle push.** Push 0x81 exactly in the last cycle of a frame's stop bit while the FIFO is empty → one IDLE cycle, then a correct 0x81 frame.

Source files
------------

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter, LSB first, fed by a small byte FIFO.
// Back-to-back queued bytes leave with no idle cycle between frames.
module uart_transmitter #(
    parameter int CYCLES_PER_BIT = 217,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                               i_clk,
    input  logic                               i_reset,
    input  logic [7:0]                         i_tx_byte,
    input  logic                               i_tx_valid,
    output logic                               o_tx_ready,
    output logic                               o_serial_tx,
    output logic                               o_tx_active,
    output logic                               o_tx_done,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    o_fifo_count,
    output logic [1:0]                         o_dbg_state
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(CYCLES_PER_BIT);
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic [BW-1:0] BIT_LAST = BW'(CYCLES_PER_BIT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [BW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            tx_q, tx_d;
    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            push;
    logic            pop;
    logic            bit_end;

    // Handshake: a byte transfers on any cycle where i_tx_valid and o_tx_ready are both high;
    // ready depends only on the registered count, so a pop in the same cycle never frees a full FIFO.
    assign o_tx_ready = (count_q < DEPTH_C);
    assign push       = i_tx_valid && o_tx_ready;
    assign bit_end    = (bit_cnt_q == BIT_LAST);

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        pop       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    pop       = 1'b1;
                    shift_d   = mem_q[rd_ptr_q];
                    bit_cnt_d = '0;
                    state_d   = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    bit_cnt_d = '0;
                    idx_d     = '0;
                    state_d   = S_DATA;
                end else begin
                    bit_cnt_d = bit_cnt_q + BW'(1);
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    bit_cnt_d = '0;
                    if (idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + BW'(1);
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    bit_cnt_d = '0;
                    // Chain straight into the next start bit when a byte is waiting.
                    if (count_q != '0) begin
                        pop     = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + BW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // The line level is computed from the next state so the output stays registered.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shift_d[idx_d];
            default: tx_d = 1'b1;
        endcase
    end

    always_comb begin
        wr_ptr_d = push ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
        rd_ptr_d = pop  ? (rd_ptr_q + PW'(1)) : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= i_tx_byte;
        end
    end

    assign o_serial_tx  = tx_q;
    assign o_tx_active  = (state_q != S_IDLE);
    assign o_tx_done    = (state_q == S_STOP) && bit_end;
    assign o_fifo_count = count_q;
    assign o_dbg_state  = state_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter with CYCLES_PER_BIT=4, FIFO_DEPTH=4.
// An independent line receiver decodes every frame and checks it against the expected byte queue.
module tb_uart_transmitter;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_byte = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       serial;
    logic       active;
    logic       done;
    logic [2:0] count;
    logic [1:0] dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] exp_q[$];
    int         start_q[$];
    int         done_q[$];
    logic [9:0] last_frame = '0;
    logic [9:0] mon_bits = '0;
    logic       mon_en = 1'b0;
    logic       mon_busy = 1'b0;
    int         mon_cyc = 0;
    logic       bitval = 1'b1;
    logic       rst_prev = 1'b0;

    typedef struct {
        logic [7:0] data;
        logic [9:0] exp_frame;
    } vec_t;
    vec_t vecs[4];

    uart_transmitter #(.CYCLES_PER_BIT(4), .FIFO_DEPTH(4)) dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_tx_byte    (tx_byte),
        .i_tx_valid   (tx_valid),
        .o_tx_ready   (tx_ready),
        .o_serial_tx  (serial),
        .o_tx_active  (active),
        .o_tx_done    (done),
        .o_fifo_count (count),
        .o_dbg_state  (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) rst_prev <= rst;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_errors);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- line monitor / scoreboard ----------------
    initial begin
        logic [7:0] exp_b;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (rst_prev) begin
                    mon_busy = 1'b0;
                    check("rst_line", serial, 1);
                    check("rst_active", active, 0);
                    check("rst_done", done, 0);
                    check("rst_count", count, 0);
                    check("rst_ready", tx_ready, 1);
                end else begin
                    if (!mon_busy && serial === 1'b0) begin
                        mon_busy = 1'b1;
                        mon_cyc  = 0;
                        start_q.push_back(int'($time));
                    end
                    if (done === 1'b1) done_q.push_back(int'($time));
                    if (mon_busy) begin
                        if (mon_cyc % 4 == 0) begin
                            bitval = serial;
                            mon_bits[mon_cyc / 4] = serial;
                        end else begin
                            check("bit_stable", serial, bitval);
                        end
                        check("active_in_frame", active, 1);
                        check("done_timing", done, (mon_cyc == 39));
                        if (mon_cyc == 39) begin
                            last_frame = mon_bits;
                            check("stop_bit", mon_bits[9], 1);
                            if (exp_q.size() == 0) begin
                                n_checks++;
                                n_errors++;
                                $display("FAIL unexpected_frame: got byte %0h expected none at t=%0t",
                                         mon_bits[8:1], $time);
                            end else begin
                                exp_b = exp_q.pop_front();
                                check("frame_byte", mon_bits[8:1], exp_b);
                            end
                            mon_busy = 1'b0;
                        end else begin
                            mon_cyc++;
                        end
                    end else begin
                        check("idle_line", serial, 1);
                        check("idle_active", active, 0);
                        check("idle_done", done, 0);
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called just after a rising edge; returns just after the accepting edge.
    task automatic push(input logic [7:0] b, output int t_acc);
        logic ok;
        int   guard;
        guard    = 0;
        t_acc    = 0;
        tx_byte  = b;
        tx_valid = 1'b1;
        do begin
            ok = tx_ready;
            @(posedge clk);
            t_acc = int'($time);
            #1;
            guard++;
        end while (!ok && guard < 200);
        tx_valid = 1'b0;
        if (ok) exp_q.push_back(b);
        else check("push_timeout", guard, 0);
    endtask

    task automatic wait_idle(input int budget);
        int g;
        g = 0;
        while ((exp_q.size() != 0 || mon_busy) && g < budget) begin
            @(negedge clk);
            g++;
        end
        check("drain_in_budget", (g < budget), 1);
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    initial begin
        int t0, t1, t2, sb, db;

        vecs[0] = '{data: 8'hA5, exp_frame: 10'b1101001010};
        vecs[1] = '{data: 8'h01, exp_frame: 10'b1000000010};
        vecs[2] = '{data: 8'h80, exp_frame: 10'b1100000000};
        vecs[3] = '{data: 8'h3C, exp_frame: 10'b1001111000};

        // Reset values
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_line", serial, 1);
        check("reset_ready", tx_ready, 1);
        check("reset_count", count, 0);
        check("reset_done", done, 0);
        check("reset_active", active, 0);
        check("reset_state", dbg_state, 0);
        @(posedge clk);
        #1;
        rst    = 1'b0;
        mon_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Single frames from a table
        for (int i = 0; i < 4; i++) begin
            sb = start_q.size();
            db = done_q.size();
            push(vecs[i].data, t0);
            check("count_after_push", count, 1);
            check("line_high_before_start", serial, 1);
            wait_idle(100);
            check("single_frame_count", start_q.size() - sb, 1);
            if (start_q.size() > sb && done_q.size() > db) begin
                check("start_latency", start_q[sb] - t0, 15);
                check("done_at_cycle_39", done_q[db] - start_q[sb], 390);
            end
            check("frame_pattern", last_frame, vecs[i].exp_frame);
            check("idle_state_after", dbg_state, 0);
        end

        // Back-to-back streaming
        sb = start_q.size();
        db = done_q.size();
        push(8'h00, t0);
        push(8'hFF, t1);
        push(8'h55, t2);
        check("b2b_push_consecutive", t2 - t0, 20);
        wait_idle(200);
        check("b2b_frames", start_q.size() - sb, 3);
        check("b2b_dones", done_q.size() - db, 3);
        if (start_q.size() >= sb + 3 && done_q.size() >= db + 3) begin
            check("b2b_first_start", start_q[sb] - t0, 15);
            for (int k = 1; k < 3; k++) begin
                check("b2b_start_gap", start_q[sb+k] - start_q[sb+k-1], 400);
                check("b2b_done_gap", done_q[db+k] - done_q[db+k-1], 400);
            end
            check("b2b_last_done", done_q[db+2] - start_q[sb], 1190);
        end

        // Full FIFO with valid held high
        begin
            int   b;
            int   g;
            logic ok;
            int   acc_t[$];
            sb = start_q.size();
            b  = 1;
            g  = 0;
            tx_valid = 1'b1;
            while (b <= 8 && g < 400) begin
                tx_byte = 8'(b);
                ok = tx_ready;
                if (!ok) check("full_count_while_blocked", count, 4);
                @(posedge clk);
                if (ok) begin
                    exp_q.push_back(8'(b));
                    acc_t.push_back(int'($time));
                    b++;
                end
                g++;
                #1;
                if (ok && b == 6) begin
                    check("full_ready_low", tx_ready, 0);
                    check("full_count4", count, 4);
                end
            end
            tx_valid = 1'b0;
            check("full_all_accepted", b, 9);
            if (acc_t.size() == 8) begin
                check("full_fill_consecutive", acc_t[4] - acc_t[0], 40);
                check("full_accept6", acc_t[5] - acc_t[0], 420);
                check("full_accept7", acc_t[6] - acc_t[5], 400);
                check("full_accept8", acc_t[7] - acc_t[6], 400);
            end
            wait_idle(500);
            check("full_frames", start_q.size() - sb, 8);
            if (start_q.size() >= sb + 8) begin
                for (int k = 1; k < 8; k++) begin
                    check("full_start_gap", start_q[sb+k] - start_q[sb+k-1], 400);
                end
            end
        end

        // Reset during data bit 3
        push(8'h3C, t0);
        push(8'hC3, t1);
        repeat (17) @(posedge clk);
        #1;
        check("pre_reset_active", active, 1);
        rst = 1'b1;
        exp_q.delete();
        sb = start_q.size();
        db = done_q.size();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_line", serial, 1);
        check("midrst_count", count, 0);
        check("midrst_active", active, 0);
        repeat (80) @(negedge clk);
        check("midrst_no_frame", start_q.size() - sb, 0);
        check("midrst_no_done", done_q.size() - db, 0);
        @(posedge clk);
        #1;

        // Push in the final stop-bit cycle with an empty FIFO
        sb = start_q.size();
        db = done_q.size();
        push(8'h5A, t0);
        repeat (40) @(posedge clk);
        #1;
        push(8'h81, t1);
        check("last_cycle_push_time", t1 - t0, 410);
        wait_idle(150);
        check("lastpush_frames", start_q.size() - sb, 2);
        if (start_q.size() >= sb + 2 && done_q.size() >= db + 2) begin
            check("lastpush_done_before_push", t1 - done_q[db], 5);
            check("lastpush_start_latency", start_q[sb+1] - t1, 15);
            check("lastpush_one_idle_gap", start_q[sb+1] - start_q[sb], 410);
        end
        check("lastpush_pattern", last_frame, 10'b1100000010);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
